// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Optional feature macro: MISALIGN_TRAP_EN (see dmem_access_ctrl.sv).
package dmem_ctrl_pkg;

  localparam int DMEM_ADDR_W = 15;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE0 = 2'b01,
    ISSUE1 = 2'b10,
    DONE   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Raw size encoding 11 is treated as a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Natural alignment check: half on even byte, word on 4-byte boundary.
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_H:    return lo[0];
      SZ_W:    return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load-data assembly: four little-endian bytes in, sign- or
// zero-extended 32-bit result out according to access size.
module dmem_load_ext
  import dmem_ctrl_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~is_unsigned & b0[7];
  assign sign_h = ~is_unsigned & b1[7];

  // Select width and fill the upper bits with the sign (or zero).
  always_comb begin
    data = '0;
    case (size)
      SZ_B:    data = {{24{sign_b}}, b0};
      SZ_H:    data = {{16{sign_h}}, b1, b0};
      default: data = {b3, b2, b1, b0};
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns 32-bit load/store requests into one or
// two beats on a byte-wide dual-port RAM (port A = even offset, port B = odd).
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned requests
// respond immediately with rsp_err=1 and never touch the RAM.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready are
// both high; req_ready is high only in IDLE and DONE, and the requester keeps
// req_valid and its payload stable until that cycle. rsp_valid is a one-cycle
// strobe with no back-pressure.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_din_a,
  output logic [7:0]        ram_din_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [7:0]        ram_dout_a,
  input  logic [7:0]        ram_dout_b
);

  state_e            state_q, state_d;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [7:0]        hold_a_q;
  logic [7:0]        hold_b_q;

  logic              accept;
  logic              mis_trap;
  logic              issuing;
  logic              beat;
  logic [ADDR_W-1:0] beat_off;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       ext_data;
  logic [7:0]        asm_b0;
  logic [7:0]        asm_b1;

  assign accept = req_valid & req_ready;

`ifdef MISALIGN_TRAP_EN
  assign mis_trap = is_misaligned(decode_size(req_size), req_addr[1:0]);
`else
  assign mis_trap = 1'b0;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the request payload on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= decode_size(req_size);
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= mis_trap;
    end
  end

  // In ISSUE1 the RAM is returning beat-0 read data; keep it for assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else if (state_q == ISSUE1) begin
      hold_a_q <= ram_dout_a;
      hold_b_q <= ram_dout_b;
    end
  end

  // Next-state decode plus status outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_d = mis_trap ? DONE : ISSUE0;
      end
      ISSUE0: begin
        busy    = 1'b1;
        state_d = (size_q == SZ_W) ? ISSUE1 : DONE;
      end
      ISSUE1: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        if (accept) state_d = mis_trap ? DONE : ISSUE0;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign issuing   = (state_q == ISSUE0) || (state_q == ISSUE1);
  assign beat      = (state_q == ISSUE1);
  assign beat_off  = {{(ADDR_W-2){1'b0}}, beat, 1'b0};
  assign base_addr = addr_q + beat_off;

  // RAM port drive, decoded from state so writes stop the moment reset hits.
  always_comb begin
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_din_a  = '0;
    ram_din_b  = '0;
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    if (issuing) begin
      ram_addr_a = base_addr;
      if (size_q != SZ_B) ram_addr_b = base_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (we_q) begin
        ram_din_a = beat ? wdata_q[23:16] : wdata_q[7:0];
        ram_din_b = beat ? wdata_q[31:24] : wdata_q[15:8];
        ram_we_a  = 1'b1;
        ram_we_b  = (size_q != SZ_B);
      end
    end
  end

  // Word loads: bytes 0-1 from the hold register, 2-3 live. Others all live.
  assign asm_b0 = (size_q == SZ_W) ? hold_a_q : ram_dout_a;
  assign asm_b1 = (size_q == SZ_W) ? hold_b_q : ram_dout_b;

  dmem_load_ext u_load_ext (
    .b0          (asm_b0),
    .b1          (asm_b1),
    .b2          (ram_dout_a),
    .b3          (ram_dout_b),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  assign rsp_rdata = (state_q == DONE && !we_q && !err_q) ? ext_data : '0;
  assign rsp_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a byte-wide two-port RAM model.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [14:0] ram_addr_a;
  logic [14:0] ram_addr_b;
  logic [7:0]  ram_din_a;
  logic [7:0]  ram_din_b;
  logic        ram_we_a;
  logic        ram_we_b;
  logic [7:0]  ram_dout_a;
  logic [7:0]  ram_dout_b;

  logic [7:0]  mem [0:32767];

  int n_tests;
  int n_fail;

  dmem_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .ram_addr_a   (ram_addr_a),
    .ram_addr_b   (ram_addr_b),
    .ram_din_a    (ram_din_a),
    .ram_din_b    (ram_din_b),
    .ram_we_a     (ram_we_a),
    .ram_we_b     (ram_we_b),
    .ram_dout_a   (ram_dout_a),
    .ram_dout_b   (ram_dout_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, registered read (read-before-write)
  always @(posedge clk) begin
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [14:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Byte/half load: ISSUE0 one cycle after acceptance, response the next.
  task automatic short_load(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [14:0] addr, input logic [31:0] exp);
    drive(1'b0, sz, uns, addr, 32'h0);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_addr_a"}, {17'b0, ram_addr_a}, {17'b0, addr});
    chk({tag, "_we_b"}, {31'b0, ram_we_b}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    tick();
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    tick();
    chk({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem[15'h7FFF] = 8'h34;
    mem[15'h0000] = 8'h12;
    mem[15'h0104] = 8'h01;
    mem[15'h0105] = 8'h02;
    mem[15'h0106] = 8'h03;
    mem[15'h0107] = 8'h04;
    mem[15'h0200] = 8'h00;
    mem[15'h0201] = 8'h00;
    mem[15'h0202] = 8'hA5;
    mem[15'h0203] = 8'h5A;

    // Reset state
    tick();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ram", {ram_addr_a, ram_din_a, ram_we_a, ram_we_b}, 32'd0);
    chk("rst_ram_b", {ram_addr_b, ram_din_b}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: SW 0x0100 0xDEADBEEF
    drive(1'b1, 2'b10, 1'b0, 15'h0100, 32'hDEADBEEF);
    chk("sw_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("sw_b0_a", {ram_addr_a, ram_din_a, 1'b0}, {15'h0100, 8'hEF, 1'b0});
    chk("sw_b0_b", {ram_addr_b, ram_din_b, 1'b0}, {15'h0101, 8'hBE, 1'b0});
    chk("sw_b0_we", {30'b0, ram_we_a, ram_we_b}, 32'd3);
    chk("sw_b0_busy", {30'b0, busy, req_ready}, 32'd2);
    tick();
    chk("sw_b1_a", {ram_addr_a, ram_din_a, 1'b0}, {15'h0102, 8'hAD, 1'b0});
    chk("sw_b1_b", {ram_addr_b, ram_din_b, 1'b0}, {15'h0103, 8'hDE, 1'b0});
    chk("sw_b1_we", {30'b0, ram_we_a, ram_we_b}, 32'd3);
    chk("sw_b1_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("sw_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("sw_rdata", rsp_rdata, 32'd0);
    chk("sw_mem", {mem[15'h0103], mem[15'h0102], mem[15'h0101], mem[15'h0100]}, 32'hDEADBEEF);
    tick();
    chk("sw_idle", {30'b0, rsp_valid, busy}, 32'd0);

    // 2: byte/half loads of the stored word
    short_load("lb",  2'b00, 1'b0, 15'h0103, 32'hFFFFFFDE);
    short_load("lbu", 2'b00, 1'b1, 15'h0103, 32'h000000DE);
    short_load("lh",  2'b01, 1'b0, 15'h0102, 32'hFFFFDEAD);

    // 3: LHU across the address wrap
`ifdef MISALIGN_TRAP_EN
    drive(1'b0, 2'b01, 1'b1, 15'h7FFF, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("trap_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("trap_err", {31'b0, rsp_err}, 32'd1);
    chk("trap_rdata", rsp_rdata, 32'd0);
    chk("trap_we", {30'b0, ram_we_a, ram_we_b}, 32'd0);
    chk("trap_busy", {31'b0, busy}, 32'd0);
    tick();
`else
    drive(1'b0, 2'b01, 1'b1, 15'h7FFF, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("wrap_addr_a", {17'b0, ram_addr_a}, 32'h7FFF);
    chk("wrap_addr_b", {17'b0, ram_addr_b}, 32'h0000);
    tick();
    chk("wrap_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("wrap_rdata", rsp_rdata, 32'h00001234);
    chk("wrap_err", {31'b0, rsp_err}, 32'd0);
    tick();
`endif

    // 4: back-to-back LW, second accepted in the DONE cycle
    drive(1'b0, 2'b10, 1'b0, 15'h0100, 32'h0);
    tick();
    drive(1'b0, 2'b10, 1'b0, 15'h0104, 32'h0);
    chk("b2b_ready_busy", {31'b0, req_ready}, 32'd0);
    tick();
    chk("b2b_issue1_addr", {17'b0, ram_addr_a}, 32'h0102);
    chk("b2b_issue1_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("b2b_rsp1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rsp1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("b2b_rsp1_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_issue0_addr", {17'b0, ram_addr_a}, 32'h0104);
    chk("b2b_issue0_rsp", {30'b0, rsp_valid, busy}, 32'd1);
    tick();
    chk("b2b_issue1b_addr", {17'b0, ram_addr_a}, 32'h0106);
    tick();
    chk("b2b_rsp2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h04030201);
    tick();
    chk("b2b_idle", {31'b0, rsp_valid}, 32'd0);

    // 5: reset during ISSUE1 of SW 0x0200 0x11223344
    drive(1'b1, 2'b10, 1'b0, 15'h0200, 32'h11223344);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rmid_we_before", {30'b0, ram_we_a, ram_we_b}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_we_drop", {30'b0, ram_we_a, ram_we_b}, 32'd0);
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    short_load("rmid_lo", 2'b01, 1'b1, 15'h0200, 32'h00003344);
    short_load("rmid_hi", 2'b01, 1'b1, 15'h0202, 32'h00005AA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
